lsu_data_align: RTL and testbench

- Byte-lane alignment block between the core's load/store path and a 32-bit word-organised data RAM.
- Store side: turns store data, address and size into a byte-replicated write word and a 4-bit byte strobe.
- Load side: takes the raw RAM word and returns the sign- or zero-extended byte, halfword or word.
- Data paths are combinational; a small clocked block records misaligned accesses.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_data_align_if.sv | 28 ++
 rtl/lsu_misalign_mon.sv | 33 +++
 rtl/lsu_data_align.sv | 104 ++++++++++
 tb/tb_lsu_data_align.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and widths for the load/store alignment slice.
package lsu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      ST_B = 2'b00,
      ST_H = 2'b01,
      ST_W = 2'b10
   } store_type_e;

   typedef enum logic [2:0] {
      LD_B  = 3'b000,
      LD_H  = 3'b001,
      LD_W  = 3'b010,
      LD_BU = 3'b100,
      LD_HU = 3'b101
   } load_type_e;

endpackage

// File: rtl/lsu_data_align_if.sv
// Core-side load/store bus of the alignment block, plus its misalignment status.
interface lsu_data_align_if #(
   parameter int CNT_W = 8
);
   logic [31:0]      addr;
   logic             mem_read;
   logic             mem_write;
   logic [1:0]       store_type;
   logic [31:0]      store_data;
   logic [31:0]      mem_wdata;
   logic [3:0]       mem_wstrb;
   logic [2:0]       load_type;
   logic [31:0]      mem_rdata;
   logic [31:0]      load_data;
   logic             misalign;
   logic             misalign_err_q;
   logic [CNT_W-1:0] misalign_cnt;

   modport master (
      output addr, mem_read, mem_write, store_type, store_data, load_type, mem_rdata,
      input  mem_wdata, mem_wstrb, load_data, misalign, misalign_err_q, misalign_cnt
   );

   modport slave (
      input  addr, mem_read, mem_write, store_type, store_data, load_type, mem_rdata,
      output mem_wdata, mem_wstrb, load_data, misalign, misalign_err_q, misalign_cnt
   );
endinterface

// File: rtl/lsu_misalign_mon.sv
// Registered misalignment pulse and saturating misaligned-access counter.
module lsu_misalign_mon #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             misalign_i,
   output logic             misalign_err_q_o,
   output logic [CNT_W-1:0] misalign_cnt_o
);

   logic             err_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (misalign_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         err_q <= misalign_i;
         cnt_q <= cnt_d;
      end
   end

   assign misalign_err_q_o = err_q;
   assign misalign_cnt_o   = cnt_q;

endmodule

// File: rtl/lsu_data_align.sv
// Byte-lane store replication/strobes and load extraction/extension for a 32-bit RAM.
// MISALIGN_TRAP_EN: suppress misaligned accesses and enable the misalignment monitor.
module lsu_data_align
   import lsu_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              rst_n,
   lsu_data_align_if.slave  bus
);

   logic [1:0]      off;
   logic [XLEN-1:0] wdata_raw;
   logic [3:0]      wstrb_raw;
   logic [XLEN-1:0] ldata_raw;
   logic [7:0]      lb;
   logic [15:0]     lh;
   logic            st_mis, ld_mis;
   logic            unused_addr;

   assign off         = bus.addr[1:0];
   assign unused_addr = ^bus.addr[31:2];

   always_comb begin
      wdata_raw = bus.store_data;
      wstrb_raw = 4'b0000;
      st_mis    = 1'b0;
      case (bus.store_type)
         ST_B: begin
            wdata_raw = {4{bus.store_data[7:0]}};
            wstrb_raw = 4'b0001 << off;
         end
         ST_H: begin
            wdata_raw = {2{bus.store_data[15:0]}};
            wstrb_raw = off[1] ? 4'b1100 : 4'b0011;
            st_mis    = off[0];
         end
         ST_W: begin
            wstrb_raw = 4'b1111;
            st_mis    = (off != 2'b00);
         end
         default: ;
      endcase
   end

   assign lb = bus.mem_rdata[{off, 3'b000} +: 8];
   assign lh = off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

   always_comb begin
      ldata_raw = '0;
      ld_mis    = 1'b0;
      case (bus.load_type)
         LD_B:  ldata_raw = {{24{lb[7]}}, lb};
         LD_BU: ldata_raw = {24'h0, lb};
         LD_H: begin
            ldata_raw = {{16{lh[15]}}, lh};
            ld_mis    = off[0];
         end
         LD_HU: begin
            ldata_raw = {16'h0, lh};
            ld_mis    = off[0];
         end
         LD_W: begin
            ldata_raw = bus.mem_rdata;
            ld_mis    = (off != 2'b00);
         end
         default: ;
      endcase
   end

   assign bus.mem_wdata = wdata_raw;

`ifdef MISALIGN_TRAP_EN
   logic misalign;
   logic unused;

   assign misalign      = (bus.mem_read & ld_mis) | (bus.mem_write & st_mis);
   assign bus.misalign  = misalign;
   assign bus.mem_wstrb = (bus.mem_write & st_mis) ? 4'b0000 : wstrb_raw;
   assign bus.load_data = (bus.mem_read & ld_mis) ? '0 : ldata_raw;
   assign unused        = unused_addr;

   lsu_misalign_mon #(.CNT_W(CNT_W)) u_mon (
      .clk              (clk),
      .rst_n            (rst_n),
      .misalign_i       (misalign),
      .misalign_err_q_o (bus.misalign_err_q),
      .misalign_cnt_o   (bus.misalign_cnt)
   );
`else
   // Status is tied off here, so the clock, reset and misalignment decode go unused.
   logic unused;

   assign bus.misalign       = 1'b0;
   assign bus.misalign_err_q = 1'b0;
   assign bus.misalign_cnt   = {CNT_W{1'b0}};
   assign bus.mem_wstrb      = wstrb_raw;
   assign bus.load_data      = ldata_raw;
   assign unused             = ^{unused_addr, clk, rst_n, st_mis, ld_mis,
                                 bus.mem_read, bus.mem_write};
`endif

endmodule

// File: tb/tb_lsu_data_align.sv
// Self-checking bench for lsu_data_align: directed vectors plus randomized reference-model checks.
module tb_lsu_data_align;

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   lsu_data_align_if #(.CNT_W(CNT_W)) bus ();

   lsu_data_align #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model, computed from access size and offset arithmetic.
   function automatic int unsigned st_bytes(input logic [1:0] st);
      case (st)
         2'd0: return 1;
         2'd1: return 2;
         2'd2: return 4;
         default: return 1;
      endcase
   endfunction

   function automatic int unsigned ld_bytes(input logic [2:0] lt);
      case (lt)
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 1;
      endcase
   endfunction

   function automatic bit m_st_mis(input logic [31:0] a, input logic [1:0] st);
      return (a % st_bytes(st)) != 0;
   endfunction

   function automatic bit m_ld_mis(input logic [31:0] a, input logic [2:0] lt);
      return (a % ld_bytes(lt)) != 0;
   endfunction

   function automatic bit m_mis(input logic [31:0] a, input bit rd, input bit wr,
                                input logic [1:0] st, input logic [2:0] lt);
      return TRAP && ((rd && m_ld_mis(a, lt)) || (wr && m_st_mis(a, st)));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] st, input logic [31:0] d);
      case (st)
         2'd0:    return (d & 32'hFF) * 32'h01010101;
         2'd1:    return (d & 32'hFFFF) * 32'h00010001;
         default: return d;
      endcase
   endfunction

   function automatic logic [3:0] m_wstrb(input logic [31:0] a, input bit wr, input logic [1:0] st);
      int unsigned o;
      o = a % 4;
      if (TRAP && wr && m_st_mis(a, st)) return 4'd0;
      case (st)
         2'd0:    return 4'(1 << o);
         2'd1:    return 4'(3 << ((o / 2) * 2));
         2'd2:    return 4'hF;
         default: return 4'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input bit rd,
                                          input logic [2:0] lt, input logic [31:0] r);
      logic [31:0] b, h;
      int unsigned o;
      o = a % 4;
      b = (r >> (8 * o)) & 32'hFF;
      h = (r >> (16 * (o / 2))) & 32'hFFFF;
      if (TRAP && rd && m_ld_mis(a, lt)) return 32'd0;
      case (lt)
         3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
         3'd2:    return r;
         3'd4:    return b;
         3'd5:    return h;
         default: return 32'd0;
      endcase
   endfunction

   // Status model follows the same clock and asynchronous reset as the DUT.
   bit m_err;
   int m_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_err <= 1'b0;
         m_cnt <= 0;
      end else begin
         m_err <= m_mis(bus.addr, bus.mem_read, bus.mem_write, bus.store_type, bus.load_type);
         if (m_mis(bus.addr, bus.mem_read, bus.mem_write, bus.store_type, bus.load_type)
             && m_cnt < CNT_MAX)
            m_cnt <= m_cnt + 1;
      end
   end

   task automatic drive(input logic [31:0] a, input bit rd, input bit wr,
                        input logic [1:0] st, input logic [31:0] sd,
                        input logic [2:0] lt, input logic [31:0] rdat);
      bus.addr = a; bus.mem_read = rd; bus.mem_write = wr;
      bus.store_type = st; bus.store_data = sd;
      bus.load_type = lt; bus.mem_rdata = rdat;
   endtask

   task automatic test_reset();
      drive(32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 3'd0, 32'h0);
      #2;
      checks++;
      if (bus.misalign_err_q !== 1'b0 || bus.misalign_cnt !== '0) begin
         errors++;
         $display("FAIL reset_state: err_q=%b cnt=%0d, expected 0/0", bus.misalign_err_q, bus.misalign_cnt);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_store_vectors();
      @(negedge clk) drive(32'h1000_0002, 1'b0, 1'b1, 2'd0, 32'hAABBCCDD, 3'd0, 32'h0);
      #1 checks++;
      if (bus.mem_wdata !== 32'hDDDDDDDD || bus.mem_wstrb !== 4'b0100 || bus.misalign !== 1'b0) begin
         errors++;
         $display("FAIL sb_off2: wdata=%h wstrb=%b mis=%b, expected DDDDDDDD/0100/0",
                  bus.mem_wdata, bus.mem_wstrb, bus.misalign);
      end
      @(negedge clk) drive(32'h1000_0002, 1'b0, 1'b1, 2'd1, 32'h12345678, 3'd0, 32'h0);
      #1 checks++;
      if (bus.mem_wdata !== 32'h56785678 || bus.mem_wstrb !== 4'b1100 || bus.misalign !== 1'b0) begin
         errors++;
         $display("FAIL sh_off2: wdata=%h wstrb=%b mis=%b, expected 56785678/1100/0",
                  bus.mem_wdata, bus.mem_wstrb, bus.misalign);
      end
      @(negedge clk) drive(32'h2000_0000, 1'b0, 1'b1, 2'd2, 32'hCAFEF00D, 3'd0, 32'h0);
      #1 checks++;
      if (bus.mem_wdata !== 32'hCAFEF00D || bus.mem_wstrb !== 4'b1111) begin
         errors++;
         $display("FAIL sw_off0: wdata=%h wstrb=%b, expected CAFEF00D/1111", bus.mem_wdata, bus.mem_wstrb);
      end
   endtask

   task automatic test_load_vectors();
      logic [31:0] exp_lb [4] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFF1, 32'hFFFFFF80};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) drive(32'h3000_0000 + 32'(i), 1'b1, 1'b0, 2'd0, 32'h0, 3'd0, 32'h80F17F01);
         #1 checks++;
         if (bus.load_data !== exp_lb[i]) begin
            errors++;
            $display("FAIL lb_off%0d: got %h expected %h", i, bus.load_data, exp_lb[i]);
         end
      end
      @(negedge clk) drive(32'h3000_0003, 1'b1, 1'b0, 2'd0, 32'h0, 3'd4, 32'h80F17F01);
      #1 checks++;
      if (bus.load_data !== 32'h00000080) begin
         errors++;
         $display("FAIL lbu_off3: got %h expected 00000080", bus.load_data);
      end
      @(negedge clk) drive(32'h3000_0002, 1'b1, 1'b0, 2'd0, 32'h0, 3'd1, 32'h80F17F01);
      #1 checks++;
      if (bus.load_data !== 32'hFFFF80F1) begin
         errors++;
         $display("FAIL lh_off2: got %h expected FFFF80F1", bus.load_data);
      end
      @(negedge clk) drive(32'h3000_0002, 1'b1, 1'b0, 2'd0, 32'h0, 3'd5, 32'h80F17F01);
      #1 checks++;
      if (bus.load_data !== 32'h000080F1) begin
         errors++;
         $display("FAIL lhu_off2: got %h expected 000080F1", bus.load_data);
      end
   endtask

   task automatic test_misalign_lw();
      logic [31:0] exp_ld;
      int          exp_cnt;
      exp_ld  = TRAP ? 32'h0 : 32'h80F17F01;
      exp_cnt = (m_cnt < CNT_MAX && TRAP) ? m_cnt + 1 : m_cnt;
      @(negedge clk) drive(32'h4000_0001, 1'b1, 1'b0, 2'd0, 32'h0, 3'd2, 32'h80F17F01);
      #1 checks++;
      if (bus.misalign !== TRAP || bus.load_data !== exp_ld) begin
         errors++;
         $display("FAIL lw_off1: mis=%b ld=%h expected %b/%h", bus.misalign, bus.load_data, TRAP, exp_ld);
      end
      @(posedge clk) #1 checks++;
      if (bus.misalign_err_q !== TRAP || bus.misalign_cnt !== CNT_W'(exp_cnt)) begin
         errors++;
         $display("FAIL lw_off1_status: err_q=%b cnt=%0d expected %b/%0d",
                  bus.misalign_err_q, bus.misalign_cnt, TRAP, exp_cnt);
      end
      @(negedge clk) drive(32'h4000_0000, 1'b0, 1'b0, 2'd0, 32'h0, 3'd0, 32'h0);
      @(posedge clk) #1 checks++;
      if (bus.misalign_err_q !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse_clears: err_q=%b expected 0", bus.misalign_err_q);
      end
   endtask

   task automatic test_reserved();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) drive(32'h5000_0000 + 32'(i), 1'b1, 1'b1, 2'd3, 32'h13579BDF, 3'd3, 32'hFFFFFFFF);
         #1 checks++;
         if (bus.load_data !== 32'h0 || bus.mem_wstrb !== 4'b0000 || bus.mem_wdata !== 32'h13579BDF) begin
            errors++;
            $display("FAIL reserved_off%0d: ld=%h wstrb=%b wdata=%h expected 0/0000/13579BDF",
                     i, bus.load_data, bus.mem_wstrb, bus.mem_wdata);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, sd, rd_w;
      logic [1:0]  st;
      logic [2:0]  lt;
      bit          rd, wr;
      for (int i = 0; i < 400; i++) begin
         a = $urandom; sd = $urandom; rd_w = $urandom;
         st = 2'($urandom_range(0, 3)); lt = 3'($urandom_range(0, 7));
         rd = 1'($urandom); wr = 1'($urandom);
         @(negedge clk) drive(a, rd, wr, st, sd, lt, rd_w);
         #1 checks++;
         if (bus.mem_wdata !== m_wdata(st, sd) || bus.mem_wstrb !== m_wstrb(a, wr, st)
             || bus.load_data !== m_load(a, rd, lt, rd_w)
             || bus.misalign !== m_mis(a, rd, wr, st, lt)) begin
            errors++;
            $display("FAIL rand_%0d: a=%h st=%0d lt=%0d rd=%b wr=%b got wd=%h ws=%b ld=%h mis=%b expected %h/%b/%h/%b",
                     i, a, st, lt, rd, wr, bus.mem_wdata, bus.mem_wstrb, bus.load_data, bus.misalign,
                     m_wdata(st, sd), m_wstrb(a, wr, st), m_load(a, rd, lt, rd_w), m_mis(a, rd, wr, st, lt));
         end
         checks++;
         if (bus.misalign_err_q !== m_err || bus.misalign_cnt !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL rand_status_%0d: err_q=%b cnt=%0d expected %b/%0d",
                     i, bus.misalign_err_q, bus.misalign_cnt, m_err, m_cnt);
         end
      end
   endtask

   task automatic test_saturation();
      int exp_cnt;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk) drive({$urandom} & 32'hFFFF_FFFC | 32'($urandom_range(1, 3)),
                              1'b0, 1'b1, 2'd2, $urandom, 3'd0, 32'h0);
         #1 checks++;
         if (bus.misalign !== TRAP || bus.mem_wstrb !== (TRAP ? 4'b0000 : 4'b1111)) begin
            errors++;
            $display("FAIL sat_sw_%0d: mis=%b wstrb=%b expected %b/%b", i, bus.misalign,
                     bus.mem_wstrb, TRAP, TRAP ? 4'b0000 : 4'b1111);
         end
      end
      exp_cnt = TRAP ? CNT_MAX : 0;
      @(posedge clk) #1 checks++;
      if (bus.misalign_cnt !== CNT_W'(exp_cnt) || bus.misalign_err_q !== TRAP) begin
         errors++;
         $display("FAIL saturate: cnt=%0d err_q=%b expected %0d/%b", bus.misalign_cnt,
                  bus.misalign_err_q, exp_cnt, TRAP);
      end
      @(negedge clk) #2 rst_n = 1'b0;
      #1 checks++;
      if (bus.misalign_cnt !== '0 || bus.misalign_err_q !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: cnt=%0d err_q=%b expected 0/0", bus.misalign_cnt, bus.misalign_err_q);
      end
      @(negedge clk) drive(32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 3'd0, 32'h0);
      rst_n = 1'b1;
      @(posedge clk) #1 checks++;
      if (bus.misalign_cnt !== '0 || bus.misalign_err_q !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: cnt=%0d err_q=%b expected 0/0", bus.misalign_cnt, bus.misalign_err_q);
      end
   endtask

   initial begin
      test_reset();
      test_store_vectors();
      test_load_vectors();
      test_misalign_lw();
      test_reserved();
      test_random();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
